alu_ctrl_decoder: RTL and testbench
===================================

// Module: alu_ctrl_decoder
// PURPOSE
//  Producer side of the ALU control interface. Decodes RV32I opcode/funct3/funct7[5] into the 4-bit alu_ctrl code and operand-B select.
//  Presents results through a valid/ready registered stage with a 2-entry skid buffer, so decode sits on a pipeline boundary ahead of the ALU.
//  Flags encodings that have no ALU meaning.
// PARAMETERS
//  CTRL_W   4   width of alu_ctrl; fixed at 4, other values unsupported
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  flush        in   1   synchronous; drops all buffered entries
//  in_valid     in   1   upstream has an instruction
//  in_ready     out  1   decoder accepts this cycle
//  opcode       in   7   instr[6:0]
//  funct3       in   3   instr[14:12]
//  funct7b5     in   1   instr[30]
//  out_valid    out  1   decoded entry available
//  out_ready    in   1   downstream consumes this cycle
//  alu_ctrl     out  4   ALU operation code
//  alu_src_imm  out  1   1 = operand B is the immediate
//  illegal      out  1   no valid ALU decode for this entry
// BEHAVIOUR
//  Codes: ADD=0000 SUB=0001 AND=0010 OR=0011 XOR=0100 SLT=0101 SLTU=0111 SLL=1000 SRA=1001 SRL=1111.
//  R-type (0110011), imm=0; funct3:
//   000 ADD/SUB(b5)   001 SLL   010 SLT   011 SLTU   100 XOR   101 SRL/SRA(b5)   110 OR   111 AND.
//   b5=1 with funct3 other than 000/101 -> illegal.
//  I-ALU (0010011), imm=1: as R-type, except 000 is always ADD; b5 selects SRA only for 101; b5=1 with 001 -> illegal.
//  Load 0000011, store 0100011, JALR 1100111, LUI 0110111, AUIPC 0010111, JAL 1101111: ADD, imm=1.
//  Branch 1100011, imm=0: 000/001 SUB; 100/101 SLT; 110/111 SLTU; 010/011 illegal.
//  Any other opcode: illegal; alu_ctrl=0000, imm=0.
//  Illegal entries are still passed downstream with illegal=1; they are never dropped.
//  Handshake:
//   - Transfer occurs when valid && ready.
//   - Latency 1 cycle: input accepted at edge N is visible at out_* after edge N.
//   - in_ready = !skid_full; it depends only on registered state, with no combinational path from out_ready.
//   - Main register holds the output entry. When the main entry stalls (out_valid && !out_ready) and an input is accepted, the input goes to the skid entry.
//   - When the main entry drains, the skid entry moves to main in the same edge.
//   - Order is strictly FIFO. Outputs stay stable while out_valid && !out_ready.
//   - Simultaneous accept and consume with an empty skid: new entry replaces main; out_valid stays 1.
//  flush: clears both entries at the next edge and overrides a simultaneous accept; in_ready=1 the following cycle.
//  Reset (async assert, sync deassert done upstream): out_valid=0, skid empty, in_ready=1, alu_ctrl=0000, alu_src_imm=0, illegal=0.
//   Reset mid-transfer discards all entries.
// CONFIGURATION
//  ALU_DEC_ILLEGAL_CHECK_EN:
//   - defined: illegal is computed as above.
//   - undefined: illegal is tied 0 and undefined encodings decode to ADD with imm=0. Saves logic for trusted fetch paths.
// STRUCTURE
//  alu_pkg: ALU_* code localparams, OP_* opcode localparams.
//  Sub-module alu_ctrl_lut: purely combinational decode of (opcode, funct3, funct7b5) -> {alu_ctrl, alu_src_imm, illegal}.
//  The top holds the main and skid registers and the handshake logic.
// TESTING
//  1. Reset -> out_valid=0, in_ready=1, alu_ctrl=0000. Send 0110011/000/b5=1 with out_ready=1 -> next cycle alu_ctrl=0001, imm=0.
//  2. Sweep all R/I funct3 values -> codes per table; 0010011/101/b5=1 gives 1001 imm=1; 0010011/001/b5=1 gives illegal=1.
//  3. Backpressure: out_ready=0, push A then B -> in_ready=0 after B; A held stable. Release out_ready -> A then B, in order, no loss.
//  4. Branch 1100011/110 -> 0111; 1100011/010 and opcode 1111111 -> illegal=1, alu_ctrl=0000.
//  5. Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed input is not captured.
//  6. Assert rst_n=0 mid-stall -> all outputs reset immediately, without waiting for a clock edge. Rebuild without the macro -> opcode 1111111 yields ADD with illegal=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, RV32I opcodes and the decoded-entry type.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       imm;
        logic       ill;
    } alu_dec_t;

endpackage

// File: rtl/alu_ctrl_lut.sv
// rtl/alu_ctrl_lut.sv - combinational RV32I decode to ALU control; ALU_DEC_ILLEGAL_CHECK_EN enables the illegal flag.
module alu_ctrl_lut
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_dec_t   dec
);

    logic [3:0] ctrl;
    logic       imm;
    logic       bad;

    always_comb begin
        ctrl = ALU_ADD;
        imm  = 1'b0;
        bad  = 1'b0;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000: ctrl = funct7b5 ? ALU_SUB : ALU_ADD;
                    3'b001: begin ctrl = ALU_SLL;  bad = funct7b5; end
                    3'b010: begin ctrl = ALU_SLT;  bad = funct7b5; end
                    3'b011: begin ctrl = ALU_SLTU; bad = funct7b5; end
                    3'b100: begin ctrl = ALU_XOR;  bad = funct7b5; end
                    3'b101: ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: begin ctrl = ALU_OR;   bad = funct7b5; end
                    default: begin ctrl = ALU_AND; bad = funct7b5; end
                endcase
            end
            OP_I: begin
                // funct7b5 is an immediate bit here except for the shift forms
                imm = 1'b1;
                case (funct3)
                    3'b000: ctrl = ALU_ADD;
                    3'b001: begin ctrl = ALU_SLL; bad = funct7b5; end
                    3'b010: ctrl = ALU_SLT;
                    3'b011: ctrl = ALU_SLTU;
                    3'b100: ctrl = ALU_XOR;
                    3'b101: ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: ctrl = ALU_OR;
                    default: ctrl = ALU_AND;
                endcase
            end
            OP_LOAD, OP_STORE, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: begin
                ctrl = ALU_ADD;
                imm  = 1'b1;
            end
            OP_BRANCH: begin
                case (funct3[2:1])
                    2'b00:   ctrl = ALU_SUB;
                    2'b10:   ctrl = ALU_SLT;
                    2'b11:   ctrl = ALU_SLTU;
                    default: bad  = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            ctrl = ALU_ADD;
            imm  = 1'b0;
        end
    end

    assign dec.ctrl = ctrl;
    assign dec.imm  = imm;
`ifdef ALU_DEC_ILLEGAL_CHECK_EN
    assign dec.ill  = bad;
`else
    assign dec.ill  = 1'b0;
`endif

endmodule

// File: rtl/alu_ctrl_decoder.sv
// rtl/alu_ctrl_decoder.sv - registered ALU control decode with 2-entry skid buffer; ALU_DEC_ILLEGAL_CHECK_EN selects illegal checking.
module alu_ctrl_decoder
    import alu_pkg::*;
#(
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              alu_src_imm,
    output logic              illegal
);

    alu_dec_t dec;
    alu_dec_t main_q;
    alu_dec_t skid_q;
    logic     main_vld;
    logic     skid_vld;
    logic     accept;
    logic     main_free;

    alu_ctrl_lut u_lut (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .dec      (dec)
    );

    assign in_ready  = !skid_vld;
    assign accept    = in_valid && in_ready;
    // main can take a new entry when it is empty or being consumed this edge
    assign main_free = !main_vld || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (main_free) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else if (accept) begin
                main_q   <= dec;
                main_vld <= 1'b1;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            skid_q   <= dec;
            skid_vld <= 1'b1;
        end
    end

    assign out_valid   = main_vld;
    assign alu_ctrl    = main_q.ctrl;
    assign alu_src_imm = main_q.imm;
    assign illegal     = main_q.ill;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// tb/tb_alu_ctrl_decoder.sv - directed and randomized checks of alu_ctrl_decoder against a queue-based model.
module tb_alu_ctrl_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7b5 = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] alu_ctrl;
    logic       alu_src_imm;
    logic       illegal;

    int n_pass = 0;
    int n_total = 0;

`ifdef ALU_DEC_ILLEGAL_CHECK_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    alu_ctrl_decoder #(.CTRL_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_ctrl    (alu_ctrl),
        .alu_src_imm (alu_src_imm),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    endtask

    // Reference decode: {ctrl, imm, illegal} from the instruction tables
    function automatic logic [5:0] ref_dec(input logic [6:0] op, input logic [2:0] f3, input logic b5);
        logic [3:0] rtab [8];
        logic [3:0] btab [8];
        logic [5:0] bad;
        rtab = '{4'h0, 4'h8, 4'h5, 4'h7, 4'h4, 4'hF, 4'h3, 4'h2};
        btab = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h5, 4'h5, 4'h7, 4'h7};
        bad  = {4'h0, 1'b0, ILL};
        if (op == 7'h33) begin
            if (b5 && f3 == 3'd0) return {4'h1, 2'b00};
            if (b5 && f3 == 3'd5) return {4'h9, 2'b00};
            if (b5) return bad;
            return {rtab[f3], 2'b00};
        end
        if (op == 7'h13) begin
            if (b5 && f3 == 3'd5) return {4'h9, 2'b10};
            if (b5 && f3 == 3'd1) return bad;
            return {rtab[f3], 2'b10};
        end
        if (op inside {7'h03, 7'h23, 7'h67, 7'h37, 7'h17, 7'h6F}) return {4'h0, 2'b10};
        if (op == 7'h63) begin
            if (f3 == 3'd2 || f3 == 3'd3) return bad;
            return {btab[f3], 2'b00};
        end
        return bad;
    endfunction

    logic [5:0] q[$];

    always @(negedge rst_n) q.delete();

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            logic acc;
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(ref_dec(opcode, funct3, funct7b5));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, q.size() < 2);
            check("out_valid", out_valid, q.size() > 0);
            if (q.size() > 0 && out_valid) begin
                check("alu_ctrl", alu_ctrl, q[0][5:2]);
                check("alu_src_imm", alu_src_imm, q[0][1]);
                check("illegal", illegal, q[0][0]);
            end
        end
    end

    task automatic step(input logic iv, input logic [6:0] op, input logic [2:0] f3,
                        input logic b5, input logic ordy, input logic fl);
        in_valid  = iv;
        opcode    = op;
        funct3    = f3;
        funct7b5  = b5;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] ops [10];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h37, 7'h17, 7'h6F, 7'h63, 7'h7F};

        // Pin the model on hand-computed entries
        check("model_sra_i", ref_dec(7'h13, 3'd5, 1'b1), 6'b1001_10);
        check("model_sub_r", ref_dec(7'h33, 3'd0, 1'b1), 6'b0001_00);
        check("model_bltu", ref_dec(7'h63, 3'd6, 1'b0), 6'b0111_00);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_ctrl", alu_ctrl, 0);
        rst_n = 1'b1;

        step(1, 7'h33, 3'd0, 1, 1, 0);
        check("sub_valid", out_valid, 1);
        check("sub_ctrl", alu_ctrl, 4'b0001);
        check("sub_imm", alu_src_imm, 0);

        for (int k = 0; k < 32; k++)
            step(1, k[4] ? 7'h13 : 7'h33, k[2:0], k[3], 1, 0);
        step(1, 7'h13, 3'd5, 1, 1, 0);
        check("srai_ctrl", alu_ctrl, 4'b1001);
        check("srai_imm", alu_src_imm, 1);
        step(1, 7'h13, 3'd1, 1, 1, 0);
        check("slli_b5_illegal", illegal, ILL);
        step(0, 7'h00, 3'd0, 0, 1, 0);

        step(1, 7'h33, 3'd4, 0, 0, 0);
        check("bp_a_ctrl", alu_ctrl, 4'b0100);
        step(1, 7'h33, 3'd6, 0, 0, 0);
        check("bp_in_ready", in_ready, 0);
        check("bp_a_held", alu_ctrl, 4'b0100);
        step(1, 7'h33, 3'd7, 0, 0, 0);
        check("bp_a_still", alu_ctrl, 4'b0100);
        step(0, 7'h00, 3'd0, 0, 1, 0);
        check("bp_b_ctrl", alu_ctrl, 4'b0011);
        step(0, 7'h00, 3'd0, 0, 1, 0);
        check("bp_drained", out_valid, 0);

        step(1, 7'h63, 3'd6, 0, 1, 0);
        check("bltu_ctrl", alu_ctrl, 4'b0111);
        step(1, 7'h63, 3'd2, 0, 1, 0);
        check("br010_illegal", illegal, ILL);
        check("br010_ctrl", alu_ctrl, 0);
        step(1, 7'h7F, 3'd0, 0, 1, 0);
        check("op7f_illegal", illegal, ILL);
        check("op7f_ctrl", alu_ctrl, 0);

        step(1, 7'h33, 3'd1, 0, 0, 0);
        step(1, 7'h33, 3'd2, 0, 0, 0);
        step(1, 7'h33, 3'd3, 0, 0, 1);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        step(0, 7'h00, 3'd0, 0, 1, 0);
        check("flush_no_capture", out_valid, 0);

        step(1, 7'h13, 3'd6, 0, 0, 0);
        step(1, 7'h13, 3'd7, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_in_ready", in_ready, 1);
        check("async_ctrl", alu_ctrl, 0);
        check("async_imm", alu_src_imm, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int k = 0; k < 3000; k++) begin
            int oi;
            oi = $urandom_range(9);
            step($urandom_range(3) != 0, ops[oi], 3'($urandom), 1'($urandom),
                 $urandom_range(2) != 0, $urandom_range(31) == 0);
        end

        step(0, 7'h00, 3'd0, 0, 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
